// File: rtl/upscale_stream_feeder_if.sv
// Stream bundle between the frame source, the feeder and the upscaler.
// master is the feeder's view, slave is the source/sink side.
interface upscale_stream_feeder_if;
    logic [7:0] s_pixel;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_pixel;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] h_phase;
    logic [1:0] v_phase;
    logic       sof;
    logic       eol;
    logic       eof;
    logic       frame_done;

    modport master (
        input  s_pixel, s_valid, m_ready,
        output s_ready, m_pixel, m_valid,
        output h_phase, v_phase, sof, eol, eof, frame_done
    );

    modport slave (
        output s_pixel, s_valid, m_ready,
        input  s_ready, m_pixel, m_valid,
        input  h_phase, v_phase, sof, eol, eof, frame_done
    );
endinterface

// File: rtl/upscale_stream_feeder.sv
// Pixel/row replicator feeding the bicubic upscaler.
// Pass 0 of each row streams live input; later passes replay a row store.
module upscale_stream_feeder #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 72,
    parameter int SCALE = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    upscale_stream_feeder_if.master  bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [1:0]    P_LAST = 2'(SCALE - 1);

    typedef enum logic {FILL, REPLAY} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [XW-1:0] x_nxt;
    logic [1:0]    h;
    logic [1:0]    v;
    logic [YW-1:0] y;
    logic [7:0]    m_pixel;
    logic          m_valid;
    logic          frame_done;
    logic [7:0]    store [IMG_W];

    logic last_h;
    logic last_x;
    logic last_v;
    logic last_y;
    logic out_fire;
    logic in_fire;
    logic row_end;
    logic s_ready;

    assign out_fire = m_valid & bus.m_ready;
    assign last_h   = (h == P_LAST);
    assign last_x   = (x == X_LAST);
    assign last_v   = (v == P_LAST);
    assign last_y   = (y == Y_LAST);
    assign row_end  = out_fire & last_h & last_x;

    // Take a new pixel only when the output slot frees up and the
    // next beat needed is fresh input rather than a replica.
    assign s_ready = rst_n & (
        ((state == FILL) & (!m_valid | (bus.m_ready & last_h & !last_x)))
        | (row_end & last_v));
    assign in_fire = bus.s_valid & s_ready;

    // x steps once the last horizontal replica of a pixel leaves.
    assign x_nxt = (out_fire & last_h) ? (last_x ? '0 : x + XW'(1)) : x;

    // Row store keeps the live row for the replay passes.
    always_ff @(posedge clk) begin
        if (in_fire) store[x_nxt] <= bus.s_pixel;
    end

    // Fill/replay sequencer: counters, output register and pass control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            x          <= '0;
            h          <= '0;
            v          <= '0;
            y          <= '0;
            m_pixel    <= '0;
            m_valid    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= row_end & last_v & last_y;
            x          <= x_nxt;
            if (out_fire) begin
                if (!last_h) begin
                    h <= h + 2'd1;
                end else begin
                    h <= '0;
                    if (!last_x) begin
                        if (state == REPLAY) m_pixel <= store[x_nxt];
                        else                 m_valid <= 1'b0;
                    end else if (!last_v) begin
                        state   <= REPLAY;
                        v       <= v + 2'd1;
                        m_pixel <= store[x_nxt];
                    end else begin
                        state   <= FILL;
                        v       <= '0;
                        y       <= last_y ? '0 : y + YW'(1);
                        m_valid <= 1'b0;
                    end
                end
            end
            if (in_fire) begin
                m_pixel <= bus.s_pixel;
                m_valid <= 1'b1;
                h       <= '0;
            end
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.m_pixel    = m_pixel;
    assign bus.m_valid    = m_valid;
    assign bus.h_phase    = h;
    assign bus.v_phase    = v;
    assign bus.sof        = m_valid & (x == '0) & (h == '0)
                          & (v == '0) & (y == '0);
    assign bus.eol        = m_valid & last_h & last_x;
    assign bus.eof        = m_valid & last_h & last_x & last_v & last_y;
    assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_upscale_stream_feeder.sv
// Bench for upscale_stream_feeder: 4x2 frames at SCALE 3 and SCALE 1.
// Beats are checked against an expected list built from nested loops.
module tb_upscale_stream_feeder;
    localparam int W = 4;
    localparam int H = 2;

    typedef struct packed {
        logic [7:0] pix;
        logic [1:0] h;
        logic [1:0] v;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    typedef struct packed {
        logic       sv;
        logic [7:0] px;
        logic       mr;
        logic       ev;
        logic       esr;
        logic [7:0] epx;
        logic [1:0] eh;
        logic       esof;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] s_pixel = '0;
    logic       s_valid = 1'b0;
    logic       m_ready = 1'b0;

    upscale_stream_feeder_if bus3 ();
    upscale_stream_feeder_if bus1 ();

    assign bus3.s_pixel = s_pixel;
    assign bus3.s_valid = s_valid & !sel;
    assign bus3.m_ready = m_ready;
    assign bus1.s_pixel = s_pixel;
    assign bus1.s_valid = s_valid & sel;
    assign bus1.m_ready = m_ready;

    upscale_stream_feeder #(.IMG_W(W), .IMG_H(H), .SCALE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));
    upscale_stream_feeder #(.IMG_W(W), .IMG_H(H), .SCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    logic [7:0] o_pix;
    logic [1:0] o_h, o_v;
    logic o_valid, o_sready, o_sof, o_eol, o_eof, o_fd;
    assign o_pix    = sel ? bus1.m_pixel    : bus3.m_pixel;
    assign o_h      = sel ? bus1.h_phase    : bus3.h_phase;
    assign o_v      = sel ? bus1.v_phase    : bus3.v_phase;
    assign o_valid  = sel ? bus1.m_valid    : bus3.m_valid;
    assign o_sready = sel ? bus1.s_ready    : bus3.s_ready;
    assign o_sof    = sel ? bus1.sof        : bus3.sof;
    assign o_eol    = sel ? bus1.eol        : bus3.eol;
    assign o_eof    = sel ? bus1.eof        : bus3.eof;
    assign o_fd     = sel ? bus1.frame_done : bus3.frame_done;

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    logic [7:0] src[$];
    beat_t expq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t cur_beat();
        return '{o_pix, o_h, o_v, o_sof, o_eol, o_eof};
    endfunction

    // Expected output: every row SCALE times, every pixel SCALE times.
    task automatic build(input int scale);
        beat_t b;
        int nfr;
        expq.delete();
        nfr = src.size() / (W * H);
        for (int f = 0; f < nfr; f++)
            for (int y = 0; y < H; y++)
                for (int v = 0; v < scale; v++)
                    for (int x = 0; x < W; x++)
                        for (int h = 0; h < scale; h++) begin
                            b.pix = src[f * W * H + y * W + x];
                            b.h   = 2'(h);
                            b.v   = 2'(v);
                            b.sof = (y == 0 && v == 0 && x == 0 && h == 0);
                            b.eol = (x == W - 1 && h == scale - 1);
                            b.eof = b.eol && v == scale - 1 && y == H - 1;
                            expq.push_back(b);
                        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("reset_state",
            {o_valid, o_pix, o_h, o_v, o_sof, o_eol, o_eof, o_fd, o_sready},
            '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_stream(input int npix, input bit rnd,
                              input int vprob, input int rprob,
                              input int abort, input int scale,
                              output int cyc, output bit aborted);
        int si, fired, total;
        bit exp_fd, prev_stall, ok;
        beat_t prev_b;
        logic prev_v;
        src.delete();
        for (int i = 0; i < npix; i++)
            src.push_back(rnd ? 8'($urandom) : 8'(i + 1));
        build(scale);
        total = expq.size();
        si = 0; fired = 0; cyc = 0; aborted = 0;
        exp_fd = 0; prev_stall = 0; prev_b = '0; prev_v = 0;
        while (fired < total && cyc < 3000) begin
            if (abort >= 0 && fired == abort) begin
                aborted = 1;
                break;
            end
            s_valid = (si < npix) && ($urandom_range(99) < vprob);
            s_pixel = (si < npix) ? src[si] : 8'($urandom);
            if (!s_valid) s_pixel = 8'($urandom);
            m_ready = ($urandom_range(99) < rprob);
            #3;
            chk("frame_done", o_fd, exp_fd);
            if (prev_stall)
                chk("hold", {o_valid, cur_beat()}, {prev_v, prev_b});
            if (o_sready) begin
                ok = !o_valid || o_v == 0
                     || (m_ready && o_eol && o_v == 2'(scale - 1));
                chk("s_ready_fill_only", ok, 1);
            end
            if (s_valid && o_sready) si++;
            if (!o_valid && fired > 0 && fired < total)
                chk("bubble_pos", {expq[fired].h, expq[fired].v}, 0);
            if (o_valid && m_ready) begin
                chk($sformatf("beat%0d", fired), cur_beat(), expq[fired]);
                fired++;
            end
            exp_fd = o_valid && m_ready && o_eof;
            prev_stall = o_valid && !m_ready;
            prev_b = cur_beat();
            prev_v = o_valid;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_valid = 1'b0;
        if (!aborted) begin
            chk("timeout", fired, total);
            #3;
            chk("frame_done_end", o_fd, exp_fd);
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vt[11];
    int cyc;
    bit ab;

    initial begin
        vt[0]  = '{1'b1, 8'd1, 1'b1, 1'b0, 1'b1, 8'd0, 2'd0, 1'b0};
        vt[1]  = '{1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd1, 2'd0, 1'b1};
        vt[2]  = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 8'd1, 2'd1, 1'b0};
        vt[3]  = '{1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd1, 2'd1, 1'b0};
        vt[4]  = '{1'b1, 8'd2, 1'b1, 1'b1, 1'b1, 8'd1, 2'd2, 1'b0};
        vt[5]  = '{1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 8'd2, 2'd0, 1'b0};
        vt[6]  = '{1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 8'd2, 2'd1, 1'b0};
        vt[7]  = '{1'b0, 8'd3, 1'b1, 1'b1, 1'b1, 8'd2, 2'd2, 1'b0};
        vt[8]  = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b1, 8'd0, 2'd0, 1'b0};
        vt[9]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 1'b0};
        vt[10] = '{1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 8'd3, 2'd0, 1'b0};

        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            s_valid = vt[i].sv;
            s_pixel = vt[i].px;
            m_ready = vt[i].mr;
            #3;
            chk($sformatf("vec%0d_ctrl", i), {o_valid, o_sready},
                {vt[i].ev, vt[i].esr});
            if (vt[i].ev)
                chk($sformatf("vec%0d_data", i), {o_pix, o_h, o_v, o_sof},
                    {vt[i].epx, vt[i].eh, 2'd0, vt[i].esof});
            @(posedge clk);
            #1;
        end

        do_reset();
        run_stream(8, 0, 100, 100, -1, 3, cyc, ab);
        chk("t1_cycles", cyc, 73);

        do_reset();
        run_stream(8, 0, 100, 50, -1, 3, cyc, ab);

        do_reset();
        run_stream(8, 1, 60, 100, -1, 3, cyc, ab);

        do_reset();
        run_stream(8, 1, 55, 70, -1, 3, cyc, ab);

        do_reset();
        run_stream(8, 0, 100, 100, 17, 3, cyc, ab);
        chk("t4_reached", ab, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_async_clear",
            {o_valid, o_pix, o_h, o_v, o_sof, o_eol, o_eof, o_fd, o_sready},
            '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        s_valid = 1'b1;
        s_pixel = 8'd9;
        m_ready = 1'b1;
        #3;
        chk("t4_s_ready", o_sready, 1);
        @(posedge clk);
        #1 s_valid = 1'b0;
        #2;
        chk("t4_restart", {o_valid, cur_beat()},
            {1'b1, 8'd9, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0});

        do_reset();
        run_stream(16, 0, 100, 100, -1, 3, cyc, ab);
        chk("t5_cycles", cyc, 145);

        sel = 1'b1;
        do_reset();
        run_stream(8, 0, 100, 100, -1, 1, cyc, ab);
        chk("t6_cycles", cyc, 9);
        do_reset();
        run_stream(8, 1, 60, 60, -1, 1, cyc, ab);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end
endmodule
